dadd_arb_ctrl: RTL and testbench

DADD_ARB_CTRL -- requirements
Module: dadd_arb_ctrl

---
 rtl/dadd_pkg.sv | 27 ++
 rtl/dadd_rr_arb.sv | 30 +++
 rtl/dadd_arb_ctrl.sv | 142 ++++++++++++++
 tb/tb_dadd_arb_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dadd_pkg.sv
// Shared definitions for the dadd arbitration controller: FSM encoding,
// default widths and the layout of the datapath configuration word.
package dadd_pkg;

    localparam int unsigned LOC_AWIDTH_DEF = 32;
    localparam int unsigned LOC_DWIDTH_DEF = 32;
    localparam int unsigned CFG_WIDTH      = 32;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    // reg_value layout: bit0 enable, bits 5:1 addend
    localparam int unsigned REG_EN_BIT    = 0;
    localparam int unsigned REG_ADD_LSB   = 1;
    localparam int unsigned REG_ADD_MSB   = 5;
    localparam int unsigned REG_ADD_WIDTH = REG_ADD_MSB - REG_ADD_LSB + 1;

    function automatic logic reg_enable(input logic [CFG_WIDTH-1:0] word);
        return word[REG_EN_BIT];
    endfunction

    function automatic logic [REG_ADD_WIDTH-1:0] reg_addend(input logic [CFG_WIDTH-1:0] word);
        return word[REG_ADD_MSB:REG_ADD_LSB];
    endfunction

endpackage

// File: rtl/dadd_rr_arb.sv
// Two-port round-robin arbiter; last_grant==1 means port 1 won last,
// so port 0 takes the first tie out of reset.
module dadd_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);

    logic last_grant;

    always_comb begin
        ready0 = en & valid0 & (~valid1 | last_grant);
        ready1 = en & valid1 & (~valid0 | ~last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (valid0 & ready0) begin
            last_grant <= 1'b0;
        end else if (valid1 & ready1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/dadd_arb_ctrl.sv
// Arbitrates two requesters onto the dadd datapath, routes results back by
// tag, and swaps the datapath configuration only once the pipe is empty.
module dadd_arb_ctrl
    import dadd_pkg::*;
#(
    parameter int unsigned LOC_AWIDTH = LOC_AWIDTH_DEF,
    parameter int unsigned LOC_DWIDTH = LOC_DWIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [LOC_DWIDTH-1:0] req0_data,
    input  logic [LOC_AWIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [LOC_DWIDTH-1:0] req1_data,
    input  logic [LOC_AWIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    input  logic                  cfg_wr_en,
    input  logic [CFG_WIDTH-1:0]  cfg_wr_data,
    output logic                  cfg_busy,
    output logic                  dadd_in_en,
    output logic [LOC_DWIDTH-1:0] dadd_in,
    output logic [LOC_AWIDTH-1:0] dadd_in_addr,
    output logic [CFG_WIDTH-1:0]  reg_value,
    input  logic                  dadd_out_en,
    input  logic [LOC_DWIDTH-1:0] dadd_out,
    input  logic [LOC_AWIDTH-1:0] dadd_out_addr,
    output logic                  rsp0_en,
    output logic                  rsp1_en,
    output logic [LOC_DWIDTH-1:0] rsp_data,
    output logic [LOC_AWIDTH-1:0] rsp_addr
);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 pending_q;
    logic                 pending_d;
    logic [CFG_WIDTH-1:0] shadow_q;
    logic [CFG_WIDTH-1:0] shadow_d;
    logic                 apply_c;
    logic                 run_c;
    logic                 acc0_c;
    logic                 acc1_c;
    logic                 tag1_q;
    logic                 tag2_q;

    assign run_c  = (state_q == ST_RUN);
    assign acc0_c = req0_valid & req0_ready;
    assign acc1_c = req1_valid & req1_ready;

    dadd_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_c),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ready0 (req0_ready),
        .ready1 (req1_ready)
    );

    // State register with the pending shadow configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pending_q <= 1'b0;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
        end
    end

    // Next state; a write landing in APPLY is kept pending and re-drains from RUN
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        apply_c   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_wr_en || pending_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!dadd_in_en) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d   = ST_RUN;
                apply_c   = 1'b1;
                pending_d = 1'b0;
            end
            default: state_d = ST_RUN;
        endcase
        if (cfg_wr_en) begin
            shadow_d  = cfg_wr_data;
            pending_d = 1'b1;
        end
    end

    // Issue register and tag pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dadd_in_en   <= 1'b0;
            dadd_in      <= '0;
            dadd_in_addr <= '0;
            tag1_q       <= 1'b0;
            tag2_q       <= 1'b0;
        end else begin
            dadd_in_en <= acc0_c | acc1_c;
            tag1_q     <= acc1_c;
            tag2_q     <= tag1_q;
            if (acc0_c) begin
                dadd_in      <= req0_data;
                dadd_in_addr <= req0_addr;
            end else if (acc1_c) begin
                dadd_in      <= req1_data;
                dadd_in_addr <= req1_addr;
            end
        end
    end

    // Configuration only changes in APPLY, when nothing is being issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_value <= '0;
        end else if (apply_c) begin
            reg_value <= shadow_q;
        end
    end

    assign cfg_busy = pending_q | ~run_c;
    assign rsp0_en  = dadd_out_en & ~tag2_q;
    assign rsp1_en  = dadd_out_en & tag2_q;
    assign rsp_data = dadd_out;
    assign rsp_addr = dadd_out_addr;

endmodule

// File: tb/tb_dadd_arb_ctrl.sv
// Directed bench for dadd_arb_ctrl with a one-cycle dadd datapath model.
module tb_dadd_arb_ctrl;
    import dadd_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int NV = 29;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_data, req1_data;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          cfg_wr_en, cfg_busy;
    logic [31:0]   cfg_wr_data, reg_value;
    logic          dadd_in_en, dadd_out_en;
    logic [DW-1:0] dadd_in, dadd_out, rsp_data;
    logic [AW-1:0] dadd_in_addr, dadd_out_addr, rsp_addr;
    logic          rsp0_en, rsp1_en;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    dadd_arb_ctrl #(.LOC_AWIDTH(AW), .LOC_DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_data(cfg_wr_data), .cfg_busy(cfg_busy),
        .dadd_in_en(dadd_in_en), .dadd_in(dadd_in), .dadd_in_addr(dadd_in_addr), .reg_value(reg_value),
        .dadd_out_en(dadd_out_en), .dadd_out(dadd_out), .dadd_out_addr(dadd_out_addr),
        .rsp0_en(rsp0_en), .rsp1_en(rsp1_en), .rsp_data(rsp_data), .rsp_addr(rsp_addr)
    );

    // Datapath model: optional add of the configured addend, one cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dadd_out_en   <= 1'b0;
            dadd_out      <= '0;
            dadd_out_addr <= '0;
        end else begin
            dadd_out_en   <= dadd_in_en;
            dadd_out      <= reg_enable(reg_value) ? dadd_in + DW'(reg_addend(reg_value)) : dadd_in;
            dadd_out_addr <= dadd_in_addr;
        end
    end

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        cfg;
        logic [31:0] cfgd;
        logic        r0;
        logic        r1;
        logic        ien;
        logic        s0;
        logic        s1;
        logic        busy;
        logic [31:0] regv;
        logic [31:0] rdata;
        logic [31:0] raddr;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1,
                                input logic cfg, input logic [31:0] cfgd, input logic r0, input logic r1,
                                input logic ien, input logic s0, input logic s1, input logic busy,
                                input logic [31:0] regv, input logic [31:0] rdata, input logic [31:0] raddr);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.cfg = cfg; v.cfgd = cfgd;
        v.r0 = r0; v.r1 = r1; v.ien = ien; v.s0 = s0; v.s1 = s1; v.busy = busy;
        v.regv = regv; v.rdata = rdata; v.raddr = raddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1,
                         input logic cfg, input logic [31:0] cfgd);
        req0_valid  = v0;
        req0_data   = d0;
        req0_addr   = 32'hA000 + d0;
        req1_valid  = v1;
        req1_data   = d1;
        req1_addr   = 32'hB000 + d1;
        cfg_wr_en   = cfg;
        cfg_wr_data = cfgd;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rsp0"}, 32'(rsp0_en), 32'd0);
        chk({tag, " rsp1"}, 32'(rsp1_en), 32'd0);
        chk({tag, " in_en"}, 32'(dadd_in_en), 32'd0);
        chk({tag, " busy"}, 32'(cfg_busy), 32'd0);
        chk({tag, " reg"}, reg_value, 32'd0);
    endtask

    initial begin
        //           v0 d0     v1 d1     cfg cfgd   r0 r1 ien s0 s1 bsy reg    rdata  raddr
        vecs[0]  = mk(1, 'h20, 1, 'h30, 0, 0,     1, 0, 0, 0, 0, 0, 'h0, 'h0,  'h0);
        vecs[1]  = mk(1, 'h21, 1, 'h31, 0, 0,     0, 1, 1, 0, 0, 0, 'h0, 'h0,  'h0);
        vecs[2]  = mk(1, 'h22, 1, 'h32, 0, 0,     1, 0, 1, 1, 0, 0, 'h0, 'h20, 'hA020);
        vecs[3]  = mk(1, 'h23, 1, 'h33, 0, 0,     0, 1, 1, 0, 1, 0, 'h0, 'h31, 'hB031);
        vecs[4]  = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 1, 1, 0, 0, 'h0, 'h22, 'hA022);
        vecs[5]  = mk(1, 'h10, 0, 'h0,  0, 0,     1, 0, 0, 0, 1, 0, 'h0, 'h33, 'hB033);
        vecs[6]  = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 1, 0, 0, 0, 'h0, 'h0,  'h0);
        vecs[7]  = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 1, 0, 0, 'h0, 'h10, 'hA010);
        vecs[8]  = mk(1, 'h40, 0, 'h0,  0, 0,     1, 0, 0, 0, 0, 0, 'h0, 'h0,  'h0);
        vecs[9]  = mk(1, 'h41, 0, 'h0,  1, 'h7,   1, 0, 1, 0, 0, 0, 'h0, 'h0,  'h0);
        vecs[10] = mk(1, 'h42, 0, 'h0,  0, 0,     0, 0, 1, 1, 0, 1, 'h0, 'h40, 'hA040);
        vecs[11] = mk(1, 'h42, 0, 'h0,  0, 0,     0, 0, 0, 1, 0, 1, 'h0, 'h41, 'hA041);
        vecs[12] = mk(1, 'h42, 0, 'h0,  0, 0,     0, 0, 0, 0, 0, 1, 'h0, 'h0,  'h0);
        vecs[13] = mk(1, 'h42, 0, 'h0,  0, 0,     1, 0, 0, 0, 0, 0, 'h7, 'h0,  'h0);
        vecs[14] = mk(1, 'h43, 0, 'h0,  0, 0,     1, 0, 1, 0, 0, 0, 'h7, 'h0,  'h0);
        vecs[15] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 1, 1, 0, 0, 'h7, 'h45, 'hA042);
        vecs[16] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 1, 0, 0, 'h7, 'h46, 'hA043);
        vecs[17] = mk(0, 'h0,  0, 'h0,  1, 'h3,   0, 0, 0, 0, 0, 0, 'h7, 'h0,  'h0);
        vecs[18] = mk(0, 'h0,  0, 'h0,  1, 'h5,   0, 0, 0, 0, 0, 1, 'h7, 'h0,  'h0);
        vecs[19] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 0, 0, 1, 'h7, 'h0,  'h0);
        vecs[20] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 0, 0, 0, 'h5, 'h0,  'h0);
        vecs[21] = mk(0, 'h0,  0, 'h0,  1, 'h9,   0, 0, 0, 0, 0, 0, 'h5, 'h0,  'h0);
        vecs[22] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 0, 0, 1, 'h5, 'h0,  'h0);
        vecs[23] = mk(0, 'h0,  0, 'h0,  1, 'hB,   0, 0, 0, 0, 0, 1, 'h5, 'h0,  'h0);
        vecs[24] = mk(1, 'h50, 0, 'h0,  0, 0,     1, 0, 0, 0, 0, 1, 'h9, 'h0,  'h0);
        vecs[25] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 1, 0, 0, 1, 'h9, 'h0,  'h0);
        vecs[26] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 1, 0, 1, 'h9, 'h54, 'hA050);
        vecs[27] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 0, 0, 1, 'h9, 'h0,  'h0);
        vecs[28] = mk(0, 'h0,  0, 'h0,  0, 0,     0, 0, 0, 0, 0, 0, 'hB, 'h0,  'h0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset dadd_in", dadd_in, 32'd0);
        chk("reset dadd_in_addr", dadd_in_addr, 32'd0);
        chk("reset ready0", 32'(req0_ready), 32'd0);
        chk("reset ready1", 32'(req1_ready), 32'd0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].cfg, vecs[i].cfgd);
            #1;
            chk($sformatf("row%0d ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("row%0d ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
            chk($sformatf("row%0d in_en", i), 32'(dadd_in_en), 32'(vecs[i].ien));
            chk($sformatf("row%0d rsp0", i), 32'(rsp0_en), 32'(vecs[i].s0));
            chk($sformatf("row%0d rsp1", i), 32'(rsp1_en), 32'(vecs[i].s1));
            chk($sformatf("row%0d busy", i), 32'(cfg_busy), 32'(vecs[i].busy));
            chk($sformatf("row%0d reg", i), reg_value, vecs[i].regv);
            if (vecs[i].s0 || vecs[i].s1) begin
                chk($sformatf("row%0d rsp_data", i), rsp_data, vecs[i].rdata);
                chk($sformatf("row%0d rsp_addr", i), rsp_addr, vecs[i].raddr);
            end
            @(negedge clk);
        end

        // Two items in flight plus a pending write, then reset mid-operation
        drive(1, 'h60, 1, 'h70, 0, 0);
        #1;
        chk("pre-rst tie ready1", 32'(req1_ready), 32'd1);
        chk("pre-rst tie ready0", 32'(req0_ready), 32'd0);
        @(negedge clk);
        drive(1, 'h60, 0, 'h0, 1, 'h3F);
        #1;
        chk("pre-rst ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pre-rst in flight", 32'(dadd_in_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("in-rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_idle($sformatf("post-rst c%0d", c));
            @(negedge clk);
        end
        drive(1, 'h80, 1, 'h90, 0, 0);
        #1;
        chk("post-rst tie ready0", 32'(req0_ready), 32'd1);
        chk("post-rst tie ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post-rst issue data", dadd_in, 32'h80);
        chk("post-rst issue addr", dadd_in_addr, 32'hA080);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
